pc_status_unit: RTL and testbench

Datapath-side endpoint of the control word. It consumes the 31-bit control word, `K` and `nextState` produced by the per-opcode decoders (B.cond, CBZ, ALU, LDUR/STUR, …). From these it owns the architectural sequential state: the 64-bit program counter, the latched NZCV flags and the 2-bit control state. It also returns the 5-bit `status` vector and the current `state` that the decoders read, closing the control/datapath loop.

---
 rtl/pc_status_unit.sv | 88 ++++++++
 tb/tb_pc_status_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_status_unit.sv
// Architectural sequential state on the datapath side of the control word:
// program counter, latched NZCV flags, control state and retired-instruction count.
module pc_status_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [30:0] controlWord,
   input  logic [63:0] K,
   input  logic [1:0]  nextState,
   input  logic [63:0] data_bus,
   input  logic [3:0]  alu_flags,
   input  logic        stall,
   output logic [63:0] pc,
   output wire  logic [63:0] pc_bus_out,
   output logic [4:0]  status,
   output logic [1:0]  state,
   output logic [31:0] retired
);

   typedef enum logic [1:0] {
      PC_HOLD = 2'b00,
      PC_INC  = 2'b01,
      PC_ABS  = 2'b10,
      PC_REL  = 2'b11
   } psel_e;

   psel_e       psel;
   logic        en_pc;
   logic        pc_sel;
   logic        sl;
   logic [63:0] pc_src;
   logic [63:0] pc_plus4;
   logic [63:0] pc_next;

   logic [63:0] pc_q;
   logic [3:0]  flags_q;   // {V, C, N, Z}, same order as alu_flags
   logic [1:0]  state_q;
   logic [31:0] retired_q;

   // Register addresses, ALU/memory enables and bus selects belong to other blocks.
   logic unused_fields;
   assign unused_fields = ^{controlWord[28:4], controlWord[2]};

   assign psel   = psel_e'(controlWord[30:29]);
   assign en_pc  = controlWord[3];
   assign pc_sel = controlWord[1];
   assign sl     = controlWord[0];

   assign pc_src   = pc_sel ? K : data_bus;
   assign pc_plus4 = pc_q + 64'd4;

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves pc_next unassigned (no latch).
      pc_next = pc_q;
      case (psel)
         PC_INC:  pc_next = pc_plus4;
         PC_ABS:  pc_next = pc_src;
         PC_REL:  pc_next = pc_plus4 + {pc_src[61:0], 2'b00};
         default: pc_next = pc_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         flags_q   <= 4'b0000;
         state_q   <= 2'b00;
         retired_q <= 32'd0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pc_q    <= pc_next;
         state_q <= nextState;
         if (sl)
            flags_q <= alu_flags;
         if (nextState == 2'b00)
            retired_q <= retired_q + 32'd1;
      end
   end

   assign pc         = pc_q;
   assign state      = state_q;
   assign retired    = retired_q;
   // Z and N swap places relative to alu_flags; bit 0 is the live ALU zero.
   assign status     = {flags_q[3], flags_q[2], flags_q[0], flags_q[1], alu_flags[0]};
   assign pc_bus_out = en_pc ? pc_plus4 : 64'bz;

endmodule

// File: tb/tb_pc_status_unit.sv
// Self-checking bench for pc_status_unit: directed scenarios plus a randomized run,
// all compared against a rule-level model of PC, flags, state and retire count.
module tb_pc_status_unit;

   localparam logic [63:0] BUS_PATTERN = 64'hA5A5_5A5A_C3C3_3C3C;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [30:0] controlWord = '0;
   logic [63:0] K = '0;
   logic [1:0]  nextState = '0;
   logic [63:0] data_bus = '0;
   logic [3:0]  alu_flags = '0;
   logic        stall = 1'b0;
   logic [63:0] pc;
   wire  [63:0] pc_bus_out;
   logic [4:0]  status;
   logic [1:0]  state;
   logic [31:0] retired;

   // Keeper on the shared bus: visible only while the DUT releases it.
   logic tb_drive = 1'b1;
   assign pc_bus_out = tb_drive ? BUS_PATTERN : 64'bz;

   int checks = 0;
   int failures = 0;

   logic [63:0] m_pc;
   logic        m_v, m_c, m_n, m_z;
   logic [1:0]  m_state;
   logic [31:0] m_ret;

   pc_status_unit #(.RESET_PC(64'h0)) dut (
      .clock(clock), .reset(reset), .controlWord(controlWord), .K(K),
      .nextState(nextState), .data_bus(data_bus), .alu_flags(alu_flags),
      .stall(stall), .pc(pc), .pc_bus_out(pc_bus_out), .status(status),
      .state(state), .retired(retired)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] exp_status();
      return {m_v, m_c, m_z, m_n, alu_flags[0]};
   endfunction

   task automatic model_reset();
      m_pc = 64'h0;
      {m_v, m_c, m_n, m_z} = 4'b0000;
      m_state = 2'b00;
      m_ret = 32'd0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".state"}, {62'd0, state}, {62'd0, m_state});
      check({tag, ".status"}, {59'd0, status}, {59'd0, exp_status()});
      check({tag, ".retired"}, {32'd0, retired}, {32'd0, m_ret});
   endtask

   // One clock of stimulus; ignored control-word fields are filled with noise.
   task automatic step(input string tag, input logic [1:0] psel, input logic pcsel,
                       input logic en, input logic sl, input logic [63:0] k,
                       input logic [63:0] db, input logic [1:0] ns,
                       input logic [3:0] fl, input logic st);
      logic [30:0] cw;
      logic [63:0] src;
      cw = 31'($urandom);
      cw[30:29] = psel;
      cw[3] = en;
      cw[1] = pcsel;
      cw[0] = sl;
      controlWord = cw;
      K = k;
      data_bus = db;
      nextState = ns;
      alu_flags = fl;
      stall = st;
      tb_drive = !en;
      #1;
      check({tag, ".bus"}, pc_bus_out, en ? m_pc + 64'd4 : BUS_PATTERN);
      check({tag, ".zi"}, {59'd0, status}, {59'd0, exp_status()});
      @(posedge clock);
      if (!st) begin
         src = pcsel ? k : db;
         case (psel)
            2'd1: m_pc = m_pc + 64'd4;
            2'd2: m_pc = src;
            2'd3: m_pc = m_pc + 64'd4 + src * 64'd4;
            default: ;
         endcase
         if (sl) {m_v, m_c, m_n, m_z} = fl;
         m_state = ns;
         if (ns == 2'b00) m_ret = m_ret + 32'd1;
      end
      #1;
      check_state(tag);
   endtask

   initial begin
      model_reset();
      // Reset held with random inputs and clock edges running.
      repeat (3) begin
         controlWord = 31'($urandom);
         K = {$urandom, $urandom};
         data_bus = {$urandom, $urandom};
         nextState = 2'($urandom);
         alu_flags = 4'($urandom);
         stall = 1'b0;
         @(posedge clock);
         #1;
         check_state("reset_hold");
      end
      @(negedge clock);
      reset = 1'b1;

      step("inc1", 2'b01, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b01, 4'h0, 1'b0);
      check("inc1.abs", pc, 64'd4);
      step("inc2", 2'b01, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'h0, 1'b0);
      check("inc2.abs", pc, 64'd8);
      step("inc3", 2'b01, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'h0, 1'b0);
      check("inc3.abs", pc, 64'd12);

      // Jump to 0x100 while latching Z=1 on the same edge.
      step("setpc", 2'b10, 1'b1, 1'b0, 1'b1, 64'h100, 64'h0, 2'b00, 4'b0001, 1'b0);
      step("branch", 2'b11, 1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 2'b00, 4'b0000, 1'b0);
      check("branch.abs", pc, 64'h144);
      check("branch.status", {59'd0, status}, 64'b00100);
      step("setpc2", 2'b10, 1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 2'b00, 4'b0000, 1'b0);
      step("notaken", 2'b01, 1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 2'b00, 4'b0000, 1'b0);
      check("notaken.abs", pc, 64'h104);

      step("busjmp", 2'b10, 1'b0, 1'b0, 1'b0, 64'h77, 64'hDEAD_BEE0, 2'b00, 4'b0000, 1'b0);
      check("busjmp.abs", pc, 64'hDEAD_BEE0);
      step("busout", 2'b00, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0);
      check("busout.abs", pc_bus_out, 64'hDEAD_BEE4);
      step("busoff", 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0);

      step("flaghold", 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'b1111, 1'b0);
      step("flagset", 2'b00, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 2'b00, 4'b1111, 1'b0);
      check("flagset.abs", {59'd0, status}, 64'b11111);

      step("stall1", 2'b01, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 2'b01, 4'b0000, 1'b1);
      step("stall2", 2'b01, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 2'b01, 4'b0000, 1'b1);
      step("unstall", 2'b01, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b01, 4'b0000, 1'b0);
      step("retire", 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0);

      step("setwrap", 2'b10, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2'b01, 4'h0, 1'b0);
      step("pcwrap", 2'b01, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 2'b01, 4'h0, 1'b0);
      check("pcwrap.abs", pc, 64'h0);

      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      m_ret = 32'hFFFF_FFFF;
      check("retforce", {32'd0, retired}, {32'd0, m_ret});
      step("retwrap", 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 2'b00, 4'h0, 1'b0);
      check("retwrap.abs", {32'd0, retired}, 64'd0);

      // Abort mid-instruction: reset acts between clock edges.
      step("midinsn", 2'b01, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 2'b10, 4'b1110, 1'b0);
      reset = 1'b0;
      #1;
      model_reset();
      check_state("asyncrst");
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 200; i++) begin
         step("rand", 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
              4'($urandom), ($urandom_range(3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
